// File: rtl/data_expander_if.sv
// ndata_i: lane-parallel element beat with per-lane keep and end-of-stream marker.
// Handshake: a beat transfers on a clock edge where valid && ready; the source holds it stable until then.
interface ndata_i #(
  parameter type data_t       = logic [7:0],
  parameter int  NUM_ELEMENTS = 8
);
  logic                    valid;
  logic                    ready;
  data_t                   data [NUM_ELEMENTS];
  logic [NUM_ELEMENTS-1:0] keep;
  logic                    last;

  modport m (output valid, data, keep, last, input ready);
  modport s (input valid, data, keep, last, output ready);
endinterface

// File: rtl/data_expander.sv
// data_expander: scatters a dense element stream into the lanes selected by a per-beat mask stream.
// Build macro DATA_EXPANDER_ZERO_FILL_EN drives unselected output lanes to zero.
module data_expander #(
  parameter type data_t       = logic [7:0],
  parameter int  NUM_ELEMENTS = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  ndata_i.s                       in,
  input  logic                    mask_valid,
  output logic                    mask_ready,
  input  logic [NUM_ELEMENTS-1:0] mask,
  input  logic                    mask_last,
  ndata_i.m                       out,
  output logic                    underflow,
  output logic                    overflow,
  output logic                    o_dbg_state
);
  localparam int N  = NUM_ELEMENTS;
  localparam int B  = 2 * N;
  localparam int NW = $clog2(N);
  localparam int IW = $clog2(B);
  localparam int CW = IW + 1;

  typedef enum logic {ST_RUN = 1'b0, ST_DRAIN = 1'b1} state_t;

  function automatic logic [CW-1:0] popcnt(input logic [N-1:0] v);
    popcnt = '0;
    for (int i = 0; i < N; i++) popcnt = popcnt + CW'(v[i]);
  endfunction

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_in_done;
  data_t           r_buf [B];
  logic            r_out_valid;
  logic            r_out_last;
  logic [N-1:0]    r_out_keep;
  data_t           r_out_data [N];
  logic            r_underflow;
  logic            r_overflow;

  logic [CW-1:0]   w_pop;
  logic [CW-1:0]   w_in_cnt;
  logic [CW-1:0]   w_used;
  logic [CW-1:0]   w_base;
  logic            w_run;
  logic            w_adv;
  logic            w_in_ready;
  logic            w_in_acc;
  logic            w_fire;
  logic            w_end_done;
  data_t           w_buf_nxt [B];
  logic [IW-1:0]   w_k [N];
  logic [N-1:0]    w_sel;
  data_t           w_lane [N];

  assign w_pop      = popcnt(mask);
  assign w_in_cnt   = popcnt(in.keep);
  assign w_run      = (r_state == ST_RUN);
  assign w_adv      = !r_out_valid || out.ready;
  assign w_in_ready = w_run ? ((r_cnt <= CW'(N)) && !r_in_done) : 1'b1;
  assign w_in_acc   = in.valid && w_in_ready;
  // Once the dense stream has ended, a short buffer no longer stalls the mask.
  assign w_fire     = w_run && mask_valid && w_adv && ((r_cnt >= w_pop) || r_in_done);
  assign w_used     = w_fire ? ((w_pop < r_cnt) ? w_pop : r_cnt) : '0;
  assign w_base     = r_cnt - w_used;
  assign w_end_done = r_in_done || (w_in_acc && in.last);

  // Shift out consumed elements and append the accepted beat behind the survivors.
  always_comb begin
    for (int j = 0; j < B; j++) begin
      w_buf_nxt[j] = r_buf[j];
      if (CW'(j) < w_base) begin
        w_buf_nxt[j] = r_buf[IW'(CW'(j) + w_used)];
      end else if (w_run && w_in_acc && (CW'(j) < w_base + w_in_cnt)) begin
        w_buf_nxt[j] = in.data[NW'(CW'(j) - w_base)];
      end
    end
  end

  // Lane i takes buffer slot k = number of selected lanes below it; missing slots read as zero.
  always_comb begin
    w_k[0] = '0;
    for (int i = 1; i < N; i++) w_k[i] = w_k[i-1] + IW'(mask[i-1]);
    for (int i = 0; i < N; i++) begin
`ifdef DATA_EXPANDER_ZERO_FILL_EN
      w_sel[i] = mask[i] && ({1'b0, w_k[i]} < r_cnt);
`else
      w_sel[i] = ({1'b0, w_k[i]} < r_cnt);
`endif
      w_lane[i] = '0;
      if (w_sel[i]) w_lane[i] = r_buf[w_k[i]];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_cnt       <= '0;
      r_in_done   <= 1'b0;
      r_out_valid <= 1'b0;
      r_underflow <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_buf <= w_buf_nxt;
      if (w_fire) begin
        r_out_valid <= 1'b1;
        r_out_keep  <= mask;
        r_out_last  <= mask_last;
        r_out_data  <= w_lane;
      end else if (w_adv) begin
        r_out_valid <= 1'b0;
      end
      case (r_state)
        ST_RUN: begin
          if (w_fire && r_in_done && (r_cnt < w_pop)) r_underflow <= 1'b1;
          if (w_fire && mask_last) begin
            // Leftover buffered elements or a beat accepted alongside the last mask are surplus.
            if ((r_cnt > w_pop) || (w_in_acc && (|in.keep))) r_overflow <= 1'b1;
            r_cnt     <= '0;
            r_in_done <= 1'b0;
            if (!w_end_done) r_state <= ST_DRAIN;
          end else begin
            r_cnt <= w_base + (w_in_acc ? w_in_cnt : '0);
            if (w_in_acc && in.last) r_in_done <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (w_in_acc) begin
            if (|in.keep) r_overflow <= 1'b1;
            if (in.last) begin
              r_state   <= ST_RUN;
              r_cnt     <= '0;
              r_in_done <= 1'b0;
            end
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign in.ready    = w_in_ready;
  assign mask_ready  = w_fire;
  assign out.valid   = r_out_valid;
  assign out.data    = r_out_data;
  assign out.keep    = r_out_keep;
  assign out.last    = r_out_last;
  assign underflow   = r_underflow;
  assign overflow    = r_overflow;
  assign o_dbg_state = r_state;
endmodule
